sync_dec_stage: RTL

- Parametrised, clocked successor to the self-timed decode stage.
- Accepts operand/instruction tokens from the fetch stage over a send/ack handshake and decodes the opcode field to one-hot at enqueue.
- Buffers up to DEPTH decoded tokens and presents them in order to the execute stage over a second send/ack handshake.
- lopen_i gates the downstream side, so the stage can be held closed while still filling.

---
 rtl/sync_dec_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sync_dec_stage.sv
// Clocked decode stage: one-hot opcode decode at enqueue, DEPTH-entry in-order buffer.
// Optional stall counter enabled by SYNC_DEC_STALL_CNT_EN.
module sync_dec_stage #(
    parameter int DATA_W = 32,
    parameter int NODE_W = 16,
    parameter int GEN_W  = 12,
    parameter int INS_W  = 34,
    parameter int OPC_W  = 4,
    parameter int DOPC_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       lopen_i,
    input  logic                       send_i,
    output logic                       ack_o,
    input  logic [NODE_W-1:0]          node_i,
    input  logic [GEN_W-1:0]           gen_i,
    input  logic [DATA_W-1:0]          opr0_i,
    input  logic [DATA_W-1:0]          opr1_i,
    input  logic                       mem_wen_i,
    input  logic [INS_W-1:0]           ins_i,
    output logic                       send_o,
    input  logic                       ack_i,
    output logic [NODE_W-1:0]          node_o,
    output logic [GEN_W-1:0]           gen_o,
    output logic [DATA_W-1:0]          opr0_o,
    output logic [DATA_W-1:0]          opr1_o,
    output logic                       mem_wen_o,
    output logic [DOPC_W-1:0]          dopc_o,
    output logic [INS_W-OPC_W-1:0]     ins_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                stall_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [NODE_W-1:0]      node;
        logic [GEN_W-1:0]       gen;
        logic [DATA_W-1:0]      opr0;
        logic [DATA_W-1:0]      opr1;
        logic                   mem_wen;
        logic [DOPC_W-1:0]      dopc;
        logic [INS_W-OPC_W-1:0] ins;
        logic                   illegal;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_ent;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [OPC_W-1:0] opc;
    logic             enq;
    logic             deq;
    logic             out_vld;

    assign opc     = ins_i[INS_W-1 -: OPC_W];
    assign ack_o   = (count < CNT_W'(DEPTH)) & ~rst;
    assign out_vld = (count != '0) & lopen_i;
    assign send_o  = out_vld;
    assign enq     = send_i & ack_o;
    assign deq     = out_vld & ack_i;
    assign count_o = count;

    always_comb begin
        wr_ent         = '0;
        wr_ent.node    = node_i;
        wr_ent.gen     = gen_i;
        wr_ent.opr0    = opr0_i;
        wr_ent.opr1    = opr1_i;
        wr_ent.mem_wen = mem_wen_i;
        wr_ent.ins     = ins_i[INS_W-OPC_W-1:0];
        for (int i = 0; i < DOPC_W; i++) begin
            wr_ent.dopc[i] = (opc == OPC_W'(i));
        end
        wr_ent.illegal = (32'(opc) >= 32'(DOPC_W));
    end

    // Buffer storage needs no reset: outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= wr_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
    end

    assign node_o    = head.node;
    assign gen_o     = head.gen;
    assign opr0_o    = head.opr0;
    assign opr1_o    = head.opr1;
    assign mem_wen_o = head.mem_wen;
    assign dopc_o    = head.dopc;
    assign ins_o     = head.ins;
    assign illegal_o = head.illegal;

`ifdef SYNC_DEC_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_vld && !ack_i && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule
